// File: rtl/mem_access_pkg.sv
// Shared encodings for the MIPS sub-word memory access unit: access sizes,
// FSM states and the alignment rule.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_t;

    // Size 11 is never legal; halves need an even address, words a multiple of 4.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: isMisaligned = 1'b0;
            SZ_HALF: isMisaligned = offset[0];
            SZ_WORD: isMisaligned = (offset != 2'b00);
            default: isMisaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane selection: extracts and extends a load lane from a word,
// and produces the word with one lane replaced by right-justified store data.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [15:0] i_store_data,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = 8'h00;
        w_half   = 16'h0000;
        o_load   = 32'h0000_0000;
        o_merged = i_word;

        // Offset 0 is the most significant byte.
        case (i_offset)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];

        case (i_size)
            SZ_BYTE: begin
                o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                case (i_offset)
                    2'd0:    o_merged[31:24] = i_store_data[7:0];
                    2'd1:    o_merged[23:16] = i_store_data[7:0];
                    2'd2:    o_merged[15:8]  = i_store_data[7:0];
                    default: o_merged[7:0]   = i_store_data[7:0];
                endcase
            end
            SZ_HALF: begin
                o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
                if (i_offset[1]) begin
                    o_merged[15:0] = i_store_data;
                end else begin
                    o_merged[31:16] = i_store_data;
                end
            end
            SZ_WORD: o_load = i_word;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage front end for a word-only DataMemory: adds byte/half loads and
// stores, running sub-word stores as a two-cycle read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Req,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] StoreData,
    output logic [DATA_W-1:0] LoadData,
    output logic              Stall,
    output logic              AddrError,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    input  logic [DATA_W-1:0] MemReadData
);

    state_t             r_state;
    logic [DATA_W-1:0]  r_oldWord;
    logic [ADDR_W-3:0]  r_wordAddr;
    logic [1:0]         r_offset;
    logic [1:0]         r_size;
    logic [15:0]        r_storeData;

    logic               w_access;
    logic               w_error;
    logic               w_subStore;
    logic [DATA_W-1:0]  w_loadValue;
    logic [DATA_W-1:0]  w_mergedWord;
    logic [DATA_W-1:0]  w_unusedExtractMerged;
    logic [DATA_W-1:0]  w_unusedMergeLoad;

    assign w_access   = Req & (MemRead | MemWrite);
    assign w_error    = w_access & isMisaligned(Size, Address[1:0]);
    assign w_subStore = w_access & MemWrite & ~w_error & (Size != SZ_WORD);

    mem_lane_align u_extract (
        .i_word       (MemReadData),
        .i_offset     (Address[1:0]),
        .i_size       (Size),
        .i_unsigned   (Unsigned),
        .i_store_data (StoreData[15:0]),
        .o_load       (w_loadValue),
        .o_merged     (w_unusedExtractMerged)
    );

    mem_lane_align u_merge (
        .i_word       (r_oldWord),
        .i_offset     (r_offset),
        .i_size       (r_size),
        .i_unsigned   (1'b0),
        .i_store_data (r_storeData),
        .o_load       (w_unusedMergeLoad),
        .o_merged     (w_mergedWord)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_oldWord   <= '0;
            r_wordAddr  <= '0;
            r_offset    <= 2'b00;
            r_size      <= 2'b00;
            r_storeData <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_subStore) begin
                        r_state     <= ST_MERGE;
                        r_oldWord   <= MemReadData;
                        r_wordAddr  <= Address[ADDR_W-1:2];
                        r_offset    <= Address[1:0];
                        r_size      <= Size;
                        r_storeData <= StoreData[15:0];
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are forced to zero during reset, which also kills a pending MERGE write.
    always_comb begin
        LoadData     = '0;
        Stall        = 1'b0;
        AddrError    = 1'b0;
        MemAddress   = '0;
        MemWriteData = '0;
        MemRead_o    = 1'b0;
        MemWrite_o   = 1'b0;
        if (Reset_n) begin
            if (r_state == ST_MERGE) begin
                MemAddress   = {r_wordAddr, 2'b00};
                MemWrite_o   = 1'b1;
                MemWriteData = w_mergedWord;
            end else begin
                MemAddress = {Address[ADDR_W-1:2], 2'b00};
                if (w_error) begin
                    AddrError = 1'b1;
                end else if (w_access && MemWrite) begin
                    if (Size == SZ_WORD) begin
                        MemWrite_o   = 1'b1;
                        MemWriteData = StoreData;
                    end else begin
                        MemRead_o = 1'b1;
                        Stall     = 1'b1;
                    end
                end else if (w_access) begin
                    MemRead_o = 1'b1;
                    LoadData  = w_loadValue;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural DataMemory;
// one table row per clock cycle plus a hand-written sub-word store sequence.
module tb_mem_access_unit;

    typedef struct {
        logic        rstN;
        logic        req;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        eStall;
        logic        eErr;
        logic        eRd;
        logic        eWr;
        logic [31:0] eLoad;
        logic [31:0] eWdata;
        logic [31:0] eMaddr;
    } vec_t;

    logic        Clk;
    logic        Reset_n;
    logic        Req;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Address;
    logic [31:0] StoreData;
    logic [31:0] LoadData;
    logic        Stall;
    logic        AddrError;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemRead_o;
    logic        MemWrite_o;
    logic [31:0] MemReadData;

    logic [31:0] mem [0:63];
    vec_t        vecs[$];
    vec_t        expQ[$];
    int          checkCount = 0;
    int          errCount   = 0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Req          (Req),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Size         (Size),
        .Unsigned     (Unsigned),
        .Address      (Address),
        .StoreData    (StoreData),
        .LoadData     (LoadData),
        .Stall        (Stall),
        .AddrError    (AddrError),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemRead_o    (MemRead_o),
        .MemWrite_o   (MemWrite_o),
        .MemReadData  (MemReadData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Word-only DataMemory: posedge write, combinational read gated by MemRead.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    end
    always @(posedge Clk) begin
        if (MemWrite_o) mem[MemAddress[7:2]] <= MemWriteData;
    end
    assign MemReadData = MemRead_o ? mem[MemAddress[7:2]] : 32'h0;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic rstN, input logic req, input logic rd, input logic wr,
                                input logic [1:0] size, input logic uns, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic eStall, input logic eErr,
                                input logic eRd, input logic eWr, input logic [31:0] eLoad,
                                input logic [31:0] eWdata, input logic [31:0] eMaddr);
        vec_t v;
        v.rstN = rstN; v.req = req; v.rd = rd; v.wr = wr; v.size = size; v.uns = uns;
        v.addr = addr; v.sdata = sdata; v.eStall = eStall; v.eErr = eErr; v.eRd = eRd;
        v.eWr = eWr; v.eLoad = eLoad; v.eWdata = eWdata; v.eMaddr = eMaddr;
        return v;
    endfunction

    task automatic compareField(input int row, input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL row %0d %s: got 0x%08h expected 0x%08h", row, name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        Reset_n   = v.rstN;
        Req       = v.req;
        MemRead   = v.rd;
        MemWrite  = v.wr;
        Size      = v.size;
        Unsigned  = v.uns;
        Address   = v.addr;
        StoreData = v.sdata;
        expQ.push_back(v);
    endtask

    task automatic checkOutput(input int row);
        vec_t e;
        if (expQ.size() == 0) begin
            compareField(row, "scoreboardEmpty", 32'd1, 32'd0);
        end else begin
            e = expQ.pop_front();
            compareField(row, "Stall",        {31'b0, Stall},      {31'b0, e.eStall});
            compareField(row, "AddrError",    {31'b0, AddrError},  {31'b0, e.eErr});
            compareField(row, "MemRead_o",    {31'b0, MemRead_o},  {31'b0, e.eRd});
            compareField(row, "MemWrite_o",   {31'b0, MemWrite_o}, {31'b0, e.eWr});
            compareField(row, "LoadData",     LoadData,            e.eLoad);
            compareField(row, "MemWriteData", MemWriteData,        e.eWdata);
            compareField(row, "MemAddress",   MemAddress,          e.eMaddr);
        end
    endtask

    initial begin
        int          stallCycles;
        logic        sawWrite;
        logic [31:0] writeData;

        Reset_n = 1'b0; Req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Size = 2'b00; Unsigned = 1'b0; Address = 32'h0; StoreData = 32'h0;

        //            rstN req rd wr size   uns addr        sdata         st er rd wr load          wdata         maddr
        vecs.push_back(mk(0, 1, 1, 0, 2'b10, 0, 32'h18, 32'h0,         0, 0, 0, 0, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 1, 2'b00, 0, 32'h19, 32'hAB,        0, 0, 0, 0, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1, 1, 0, 1, 2'b10, 0, 32'h18, 32'h12345678,  0, 0, 0, 1, 32'h0,        32'h12345678, 32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b10, 0, 32'h18, 32'h0,         0, 0, 1, 0, 32'h12345678, 32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 0, 1, 2'b00, 0, 32'h19, 32'hAB,        1, 0, 1, 0, 32'h0,        32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 0, 1, 2'b00, 0, 32'h19, 32'hAB,        0, 0, 0, 1, 32'h0,        32'h12AB5678, 32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b10, 0, 32'h18, 32'h0,         0, 0, 1, 0, 32'h12AB5678, 32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b00, 0, 32'h19, 32'h0,         0, 0, 1, 0, 32'hFFFFFFAB, 32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b00, 1, 32'h19, 32'h0,         0, 0, 1, 0, 32'h000000AB, 32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b01, 0, 32'h1A, 32'h0,         0, 0, 1, 0, 32'h00005678, 32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b00, 0, 32'h18, 32'h0,         0, 0, 1, 0, 32'h00000012, 32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 0, 1, 2'b01, 0, 32'h1A, 32'hBEEF,      1, 0, 1, 0, 32'h0,        32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 0, 1, 2'b01, 0, 32'h1A, 32'hBEEF,      0, 0, 0, 1, 32'h0,        32'h12ABBEEF, 32'h18));
        vecs.push_back(mk(1, 1, 0, 1, 2'b00, 0, 32'h18, 32'h00,        1, 0, 1, 0, 32'h0,        32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 0, 1, 2'b00, 0, 32'h18, 32'h00,        0, 0, 0, 1, 32'h0,        32'h00ABBEEF, 32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b10, 0, 32'h18, 32'h0,         0, 0, 1, 0, 32'h00ABBEEF, 32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b10, 0, 32'h1A, 32'h0,         0, 1, 0, 0, 32'h0,        32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 0, 1, 2'b01, 0, 32'h1B, 32'h1111,      0, 1, 0, 0, 32'h0,        32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b10, 0, 32'h18, 32'h0,         0, 0, 1, 0, 32'h00ABBEEF, 32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 0, 1, 2'b00, 0, 32'h18, 32'hFF,        1, 0, 1, 0, 32'h0,        32'h0,        32'h18));
        vecs.push_back(mk(0, 1, 0, 1, 2'b00, 0, 32'h18, 32'hFF,        0, 0, 0, 0, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1, 1, 1, 0, 2'b10, 0, 32'h18, 32'h0,         0, 0, 1, 0, 32'h00ABBEEF, 32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b01, 0, 32'h18, 32'h0,         0, 0, 1, 0, 32'h000000AB, 32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b01, 0, 32'h1A, 32'h0,         0, 0, 1, 0, 32'hFFFFBEEF, 32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b01, 1, 32'h1A, 32'h0,         0, 0, 1, 0, 32'h0000BEEF, 32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b00, 0, 32'h1B, 32'h0,         0, 0, 1, 0, 32'hFFFFFFEF, 32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b11, 0, 32'h18, 32'h0,         0, 1, 0, 0, 32'h0,        32'h0,        32'h18));
        vecs.push_back(mk(1, 0, 1, 0, 2'b10, 0, 32'h18, 32'h0,         0, 0, 0, 0, 32'h0,        32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 1, 1, 2'b00, 0, 32'h1B, 32'h5A,        1, 0, 1, 0, 32'h0,        32'h0,        32'h18));
        vecs.push_back(mk(1, 1, 1, 1, 2'b00, 0, 32'h1B, 32'h5A,        0, 0, 0, 1, 32'h0,        32'h00ABBE5A, 32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 2'b10, 0, 32'h18, 32'h0,         0, 0, 1, 0, 32'h00ABBE5A, 32'h0,        32'h18));

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge Clk);
            applyStimulus(vecs[r]);
            #2;
            checkOutput(r);
        end

        // Byte store into an untouched word: count stall cycles until the write appears.
        @(negedge Clk);
        Reset_n = 1'b1; Req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1;
        Size = 2'b00; Unsigned = 1'b0; Address = 32'h22; StoreData = 32'h77;
        stallCycles = 0;
        sawWrite    = 1'b0;
        writeData   = 32'h0;
        for (int c = 0; c < 4 && !sawWrite; c++) begin
            #2;
            if (Stall) stallCycles++;
            if (MemWrite_o) begin
                sawWrite  = 1'b1;
                writeData = MemWriteData;
            end
            @(negedge Clk);
        end
        compareField(-1, "seqSawWrite",    {31'b0, sawWrite}, 32'd1);
        compareField(-1, "seqStallCycles", stallCycles,       32'd1);
        compareField(-1, "seqMergedWord",  writeData,         32'h00007700);
        applyStimulus(mk(1, 1, 1, 0, 2'b10, 0, 32'h20, 32'h0, 0, 0, 1, 0, 32'h00007700, 32'h0, 32'h20));
        #2;
        checkOutput(vecs.size());

        @(negedge Clk);
        Req = 1'b0;
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sits between the MEM pipeline stage and the word-only `DataMemory`, adding MIPS byte and halfword loads and stores. Loads and word stores pass straight through in one cycle. Sub-word stores run a two-cycle read-modify-write, and the unit stalls the pipeline for the first cycle. Misaligned accesses are blocked and flagged.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; must be 32.

Ports:
- `Clk` in 1: rising-edge clock.
- `Reset_n` in 1: synchronous, active-low reset.
- `Req` in 1: a memory instruction is valid in the MEM stage.
- `MemRead` in 1: the request is a load.
- `MemWrite` in 1: the request is a store.
- `Size` in 2: 00 byte, 01 half, 10 word; 11 is illegal and treated as an error.
- `Unsigned` in 1: zero-extend loads (lbu/lhu) instead of sign-extending.
- `Address` in 32: byte address.
- `StoreData` in 32: store value, right-justified.
- `LoadData` out 32: extracted and extended load result.
- `Stall` out 1: hold the pipeline.
- `AddrError` out 1: the access is misaligned or has an illegal size.
- `MemAddress` out 32: to `DataMemory.Address`; word aligned, bits [1:0] = 00.
- `MemWriteData` out 32: to `DataMemory.WriteData`.
- `MemRead_o` out 1: to `DataMemory.MemRead`.
- `MemWrite_o` out 1: to `DataMemory.MemWrite`.
- `MemReadData` in 32: from `DataMemory.ReadData`.

## Operation
- Memory model: `DataMemory` writes at the posedge and reads combinationally; its `ReadData` is 0 when `MemRead` = 0.
- Byte order is big-endian:
  - Byte offset 0 → bits [31:24]; offset 3 → bits [7:0].
  - Half offset 0 → bits [31:16]; offset 2 → bits [15:0].
- Alignment errors are combinational:
  - half with `Address[0]` = 1;
  - word with `Address[1:0]` ≠ 00;
  - `Size` = 11.
- On an error: `AddrError` = 1, `MemRead_o` = 0, `MemWrite_o` = 0, `LoadData` = 0, `Stall` = 0. The error check has priority over everything else.
- `MemRead` and `MemWrite` both high with `Req` is treated as a store.
- FSM has two states, IDLE and MERGE.
- IDLE:
  - Load: `MemRead_o` = 1. `LoadData` = selected lane of `MemReadData`, sign- or zero-extended, in the same cycle.
  - Word store: `MemWrite_o` = 1, `MemWriteData` = `StoreData`, written at the posedge.
  - Sub-word store: `MemRead_o` = 1 and `Stall` = 1. At the posedge, latch `MemReadData` into OldWord and latch address, offset, size and store data. Next state is MERGE.
- MERGE:
  - `MemWrite_o` = 1, `Stall` = 0.
  - `MemWriteData` = OldWord with the latched lane replaced by `StoreData[7:0]` or `StoreData[15:0]`.
  - The address comes from the latch; `Req` inputs are ignored (upstream holds them stable during the stall).
  - Next state is IDLE.
- `MemAddress` = {`Address[31:2]`, 2'b00} in IDLE, and the latched word address in MERGE.
- Reset:
  - While `Reset_n` = 0, all outputs are 0 and the state is IDLE at the next posedge.
  - Reset asserted during MERGE: the cycle's write is suppressed and the memory word is unchanged.

## Timing
- Load latency: 0 cycles, combinational through `DataMemory`. The pipeline samples `LoadData` at the end of the MEM cycle.
- Word store: 1 cycle, no stall.
- Sub-word store: 2 cycles, `Stall` high for exactly the first cycle.
- Back-to-back sub-word stores: the next request is accepted in the IDLE cycle right after MERGE. No bubble beyond the single stall.
- A load immediately after a sub-word store sees the merged word, because the write lands at the MERGE posedge.
- Reset values: `Stall` 0, `AddrError` 0, `MemRead_o` 0, `MemWrite_o` 0, `LoadData` 0, `MemWriteData` 0, `MemAddress` 0, OldWord 0.

## Structure
- Package `mem_access_pkg` holds:
  - the size encodings `SZ_BYTE` / `SZ_HALF` / `SZ_WORD`;
  - the state encoding `ST_IDLE` / `ST_MERGE`.
- Sub-module `mem_lane_align` is purely combinational. From (word, offset, size, unsigned, store data) it produces the extracted/extended load value and the merged store word. It is instantiated once for extract and once for merge.
- Top level contains the FSM, the latches and the output muxing.

## Test plan
1. **Word store then load.** sw 0x12345678 @0x18, then lw @0x18 → `LoadData` = 0x12345678; `Stall` never asserts.
2. **Byte store.** sb 0xAB @0x19 → `Stall` = 1 for one cycle with `MemRead_o` = 1. Next cycle `MemWrite_o` = 1, `MemWriteData` = 0x12AB5678. A following lw @0x18 → 0x12AB5678.
3. **Sub-word loads.**
   - lb @0x19 → 0xFFFFFFAB.
   - lbu @0x19 → 0x000000AB.
   - lh @0x1A → 0x00005678.
   - lb @0x18 → 0x00000012.
4. **Halfword store.** sh 0xBEEF @0x1A → written word 0x12ABBEEF. A back-to-back sb 0x00 @0x18 → 0x00ABBEEF, with exactly one stall cycle per store.
5. **Misaligned accesses.**
   - lw @0x1A → `AddrError` = 1, `MemRead_o` = 0, `LoadData` = 0.
   - sh @0x1B → `AddrError` = 1, no write; word @0x18 unchanged.
6. **Reset mid-operation.** sb 0xFF @0x18 with `Reset_n` = 0 asserted in the MERGE cycle → no write; the word is still 0x00ABBEEF; the unit is IDLE and all outputs are 0.
